// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the block-unpacker state encoding.
package aes_pkg;

  localparam int AES_BLOCK_WIDTH = 128;
  localparam int AES_WORD_WIDTH  = 32;

  typedef enum logic [1:0] {
    UNP_IDLE = 2'd0,
    UNP_LOAD = 2'd1,
    UNP_SEND = 2'd2
  } unpack_state_t;

endpackage

// File: rtl/fifo_unpacker.sv
// Pops one block at a time from the block FIFO and streams it out as
// WORD_WIDTH-bit words, most-significant word first, over valid/ready.
module fifo_unpacker
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH = AES_BLOCK_WIDTH,
  parameter int WORD_WIDTH = AES_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty_i,
  output logic                  fifo_pop_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic                  busy_o
);

  localparam int NUM_WORDS = DATA_WIDTH / WORD_WIDTH;
  localparam int IDX_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

  if (DATA_WIDTH % WORD_WIDTH != 0) begin : g_width_check
    $error("fifo_unpacker: DATA_WIDTH must be a multiple of WORD_WIDTH");
  end

  unpack_state_t         r_state;
  unpack_state_t         w_next_state;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic                  w_handshake;
  logic                  w_last;

  assign w_handshake = (r_state == UNP_SEND) & ready_i;
  assign w_last      = (r_idx == LAST_IDX);

  // State, word index and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= UNP_IDLE;
      r_idx   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        UNP_LOAD: begin
          r_shreg <= fifo_data_i;
          r_idx   <= '0;
        end
        UNP_SEND: begin
          if (w_handshake && !w_last) begin
            r_shreg <= r_shreg << WORD_WIDTH;
            r_idx   <= r_idx + IDX_WIDTH'(1);
          end else if (w_handshake) begin
            r_idx <= '0;
          end else begin
            r_idx <= r_idx;
          end
        end
        default: begin
          r_idx <= r_idx;
        end
      endcase
    end
  end

  // Next-state decode and output drive; pops only ever issue on a non-empty FIFO.
  always_comb begin
    w_next_state = r_state;
    fifo_pop_o   = 1'b0;
    valid_o      = 1'b0;
    last_o       = 1'b0;
    word_o       = '0;
    case (r_state)
      UNP_IDLE: begin
        fifo_pop_o = ~fifo_empty_i;
        if (!fifo_empty_i) begin
          w_next_state = UNP_LOAD;
        end else begin
          w_next_state = UNP_IDLE;
        end
      end
      UNP_LOAD: begin
        w_next_state = UNP_SEND;
      end
      UNP_SEND: begin
        valid_o = 1'b1;
        word_o  = r_shreg[DATA_WIDTH-1 -: WORD_WIDTH];
        last_o  = w_last;
        if (w_handshake && w_last) begin
          // Back-to-back: pop the next block in the same cycle the last word leaves.
          fifo_pop_o   = ~fifo_empty_i;
          w_next_state = fifo_empty_i ? UNP_IDLE : UNP_LOAD;
        end else begin
          w_next_state = UNP_SEND;
        end
      end
      default: begin
        w_next_state = UNP_IDLE;
      end
    endcase
  end

  assign busy_o = (r_state != UNP_IDLE);

endmodule

// File: tb/tb_fifo_unpacker.sv
// Scoreboard bench for fifo_unpacker: a queue-based FIFO model feeds the DUT,
// expected words are derived from each pushed block and checked by a monitor.
module tb_fifo_unpacker;
  import aes_pkg::*;

  localparam int DW = AES_BLOCK_WIDTH;
  localparam int WW = AES_WORD_WIDTH;
  localparam int NW = DW / WW;

  typedef struct {
    logic [WW-1:0] w;
    logic          l;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          fifo_empty_i;
  logic          fifo_pop_o;
  logic [DW-1:0] fifo_data_i;
  logic [WW-1:0] word_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_o;
  logic          busy_o;

  fifo_unpacker #(.DATA_WIDTH(DW), .WORD_WIDTH(WW)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (fifo_empty_i),
    .fifo_pop_o   (fifo_pop_o),
    .fifo_data_i  (fifo_data_i),
    .word_o       (word_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .last_o       (last_o),
    .busy_o       (busy_o)
  );

  logic [DW-1:0] fifo_q[$];
  exp_t          exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            pops = 0;
  int            last_pop_cyc = -1;
  int            first_word_cyc = -1;
  int            last_hs_cyc = -1;
  int            gap_cnt = 0;
  int            hs_cnt = 0;
  bit            rand_ready = 0;
  bit            do_pop;
  bit            prev_pend = 0;
  logic [WW-1:0] prev_word;
  logic          prev_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model of the block FIFO: entries are whole blocks, split MSW-first for the scoreboard.
  task automatic push_block(input logic [DW-1:0] b);
    exp_t e;
    fifo_q.push_back(b);
    for (int i = 0; i < NW; i++) begin
      e.w = WW'(b >> (WW * (NW - 1 - i)));
      e.l = (i == NW - 1);
      exp_q.push_back(e);
    end
  endtask

  // FIFO model: registered read data one cycle after a pop, zero otherwise.
  always begin
    @(posedge clk);
    cyc++;
    do_pop = fifo_pop_o && !rst;
    if (do_pop) begin
      pops++;
      last_pop_cyc = cyc;
      check("pop_while_empty", DW'(fifo_empty_i), DW'(0));
    end
    #2;
    if (do_pop && fifo_q.size() != 0) fifo_data_i = fifo_q.pop_front();
    else fifo_data_i = '0;
    fifo_empty_i = (fifo_q.size() == 0);
  end

  // Random sink readiness.
  always begin
    @(posedge clk);
    #1;
    if (rand_ready) ready_i = 1'($urandom_range(0, 1));
  end

  // Monitor: scoreboard compare on handshakes, stability check under backpressure.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_pend = 0;
    end else begin
      if (prev_pend) begin
        check("hold_valid", DW'(valid_o), DW'(1));
        check("hold_word", DW'(word_o), DW'(prev_word));
        check("hold_last", DW'(last_o), DW'(prev_last));
      end
      if (valid_o) begin
        if (first_word_cyc < 0) first_word_cyc = cyc;
      end else if (busy_o && first_word_cyc >= 0) begin
        gap_cnt++;
      end
      if (valid_o && ready_i) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h with empty scoreboard", word_o);
        end else begin
          e = exp_q.pop_front();
          check("word", DW'(word_o), DW'(e.w));
          check("last", DW'(last_o), DW'(e.l));
        end
      end
      prev_pend = valid_o && !ready_i;
      prev_word = word_o;
      prev_last = last_o;
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (n < budget) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && fifo_q.size() == 0 && !busy_o) break;
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: %0d words still expected after %0d cycles", exp_q.size(), budget);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] b1;
    int t0;
    int p0;
    b1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    rst = 1'b1;
    ready_i = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_data_i = '0;
    step();
    step();
    check("rst_outputs", DW'({fifo_pop_o, valid_o, last_o, busy_o}), DW'(0));
    check("rst_word", DW'(word_o), DW'(0));
    rst = 1'b0;
    step();

    // Single block with latency checks.
    ready_i = 1'b1;
    first_word_cyc = -1;
    p0 = pops;
    t0 = cyc;
    push_block(b1);
    wait_idle(50);
    check("pop_latency", DW'(last_pop_cyc - t0), DW'(1));
    check("first_word_latency", DW'(first_word_cyc - t0), DW'(2));
    check("block_span", DW'(last_hs_cyc - first_word_cyc), DW'(NW - 1));
    check("single_pops", DW'(pops - p0), DW'(1));
    check("idle_busy", DW'(busy_o), DW'(0));

    // Three queued blocks back to back.
    first_word_cyc = -1;
    gap_cnt = 0;
    p0 = pops;
    for (int i = 0; i < 3; i++) push_block({$urandom(), $urandom(), $urandom(), $urandom()});
    wait_idle(100);
    check("b2b_span", DW'(last_hs_cyc - first_word_cyc), DW'(2 * (NW + 1) + NW - 1));
    check("b2b_load_gaps", DW'(gap_cnt), DW'(2));
    check("b2b_pops", DW'(pops - p0), DW'(3));

    // Backpressure on word 1.
    p0 = pops;
    push_block(b1);
    repeat (3) step();
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", DW'(valid_o), DW'(1));
      check("bp_word", DW'(word_o), DW'(32'h44556677));
      step();
    end
    check("bp_word_end", DW'(word_o), DW'(32'h44556677));
    check("bp_pops", DW'(pops - p0), DW'(1));
    ready_i = 1'b1;
    wait_idle(50);

    // Empty FIFO stays quiet.
    for (int i = 0; i < 20; i++) begin
      step();
      check("empty_quiet", DW'({fifo_pop_o, valid_o, busy_o}), DW'(0));
    end

    // Reset in the middle of a block.
    push_block(b1);
    repeat (4) step();
    check("pre_rst_word2", DW'(word_o), DW'(32'h8899AABB));
    ready_i = 1'b0;
    rst = 1'b1;
    step();
    check("mid_rst_outputs", DW'({fifo_pop_o, valid_o, last_o, busy_o}), DW'(0));
    check("mid_rst_word", DW'(word_o), DW'(0));
    exp_q.delete();
    fifo_q.delete();
    rst = 1'b0;
    ready_i = 1'b1;
    step();
    push_block(128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D);
    wait_idle(50);

    // Random blocks with random readiness.
    p0 = pops;
    rand_ready = 1;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 6)) step();
      push_block({$urandom(), $urandom(), $urandom(), $urandom()});
    end
    wait_idle(3000);
    rand_ready = 0;
    ready_i = 1'b1;
    check("rand_pops", DW'(pops - p0), DW'(8));
    check("rand_scoreboard_empty", DW'(exp_q.size()), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
